// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: handshaked instruction intake, decode, execute, memory wait, branch and writeback.
// Optional retire counter output enabled by defining CTRL_RETIRE_COUNT_EN.
module legv8_multicycle_ctrl #(
  parameter int REG_AW      = 5,
  parameter int IMM_W       = 7,
  parameter int INSTR_W     = 10 + 3*REG_AW + IMM_W,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output logic               mem_write_dm,
  output logic               mem_read_dm,
  output logic               branch,
  output logic               reg_write_rf,
  output logic               mux2,
  output logic               mux3,
  output logic [REG_AW-1:0]  read_reg_1,
  output logic [REG_AW-1:0]  read_reg_2,
  output logic [REG_AW-1:0]  write_reg,
  output logic [IMM_W-1:0]   sign_extension_bits,
  output logic [2:0]         alu_op,
  output logic               busy,
  output logic               illegal_op,
  output logic               mem_err,
  output logic               halted
`ifdef CTRL_RETIRE_COUNT_EN
  ,
  output logic [31:0]        retire_count
`endif
);

  if (INSTR_W != 10 + 3*REG_AW + IMM_W) begin : g_bad_instr_w
    $error("INSTR_W must equal 10 + 3*REG_AW + IMM_W");
  end
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be in 1..255");
  end

  localparam int IMM_LO = 2*REG_AW;
  localparam int RN_LO  = 2*REG_AW + IMM_W;

  localparam logic [9:0] OP_ADD  = 10'h228;
  localparam logic [9:0] OP_SUB  = 10'h32C;
  localparam logic [9:0] OP_DIV  = 10'h01F;
  localparam logic [9:0] OP_MUL  = 10'h3E0;
  localparam logic [9:0] OP_LDI  = 10'h2AA;
  localparam logic [9:0] OP_STUR = 10'h3D8;
  localparam logic [9:0] OP_LDUR = 10'h3DA;
  localparam logic [9:0] OP_CBZ  = 10'h2D0;
  localparam logic [9:0] OP_HALT = 10'h354;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_BR, S_WB, S_HALT
  } state_t;

  state_t             state;
  logic [INSTR_W-1:0] instr_q;
  logic [7:0]         wait_cnt;

  logic [9:0]        op_q;
  logic [REG_AW-1:0] f_rd, f_rm, f_rn;
  logic [IMM_W-1:0]  f_imm;

  assign op_q  = instr_q[INSTR_W-1 -: 10];
  assign f_rd  = instr_q[REG_AW-1:0];
  assign f_rm  = instr_q[2*REG_AW-1:REG_AW];
  assign f_imm = instr_q[RN_LO-1:IMM_LO];
  assign f_rn  = instr_q[RN_LO+REG_AW-1:RN_LO];

  // Outputs are updated on the edge that enters a state, so they line up with that state's cycle;
  // the pulse outputs default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      instr_q             <= '0;
      wait_cnt            <= '0;
      instr_ready         <= 1'b0;
      mem_write_dm        <= 1'b0;
      mem_read_dm         <= 1'b0;
      branch              <= 1'b0;
      reg_write_rf        <= 1'b0;
      mux2                <= 1'b0;
      mux3                <= 1'b0;
      read_reg_1          <= '0;
      read_reg_2          <= '0;
      write_reg           <= '0;
      sign_extension_bits <= '0;
      alu_op              <= 3'b101;
      busy                <= 1'b0;
      illegal_op          <= 1'b0;
      mem_err             <= 1'b0;
      halted              <= 1'b0;
    end else begin
      illegal_op   <= 1'b0;
      mem_err      <= 1'b0;
      branch       <= 1'b0;
      reg_write_rf <= 1'b0;
      case (state)
        S_IDLE: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          if (instr_valid && instr_ready && instruction != '0) begin
            instr_q     <= instruction;
            state       <= S_DECODE;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_DECODE: begin
          read_reg_1          <= f_rn;
          read_reg_2          <= f_rm;
          write_reg           <= f_rd;
          sign_extension_bits <= f_imm;
          mux2                <= 1'b0;
          wait_cnt            <= '0;
          case (op_q)
            OP_ADD:  begin alu_op <= 3'b010; mux3 <= 1'b1; state <= S_EXEC; end
            OP_SUB:  begin alu_op <= 3'b001; mux3 <= 1'b1; state <= S_EXEC; end
            OP_DIV:  begin alu_op <= 3'b011; mux3 <= 1'b1; state <= S_EXEC; end
            OP_MUL:  begin alu_op <= 3'b100; mux3 <= 1'b1; state <= S_EXEC; end
            OP_LDI: begin
              alu_op     <= 3'b010;
              mux3       <= 1'b0;
              read_reg_1 <= '0;
              state      <= S_EXEC;
            end
            OP_STUR, OP_LDUR: begin
              alu_op       <= 3'b010;
              mux3         <= 1'b0;
              mem_read_dm  <= (op_q == OP_LDUR);
              mem_write_dm <= (op_q == OP_STUR);
              state        <= S_MEM;
            end
            OP_CBZ:  begin alu_op <= 3'b101; mux3 <= 1'b1; state <= S_BR; end
            OP_HALT: begin halted <= 1'b1; state <= S_HALT; end
            default: begin
              illegal_op  <= 1'b1;
              instr_ready <= 1'b1;
              busy        <= 1'b0;
              state       <= S_IDLE;
            end
          endcase
        end
        S_EXEC: begin
          reg_write_rf <= (write_reg != '0);
          state        <= S_WB;
        end
        S_MEM: begin
          if (mem_ready || wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
            mem_read_dm  <= 1'b0;
            mem_write_dm <= 1'b0;
          end
          if (mem_ready && op_q == OP_LDUR) begin
            mux2         <= 1'b1;
            reg_write_rf <= (write_reg != '0);
            state        <= S_WB;
          end else if (mem_ready || wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
            mem_err     <= !mem_ready;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_BR, S_WB: begin
          branch      <= (state == S_BR) && alu_zero;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        S_HALT: begin
          instr_ready <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CTRL_RETIRE_COUNT_EN
  logic retire_now;
  assign retire_now = (state == S_WB) || (state == S_BR) ||
                      (state == S_MEM && mem_ready && op_q == OP_STUR);

  always_ff @(posedge clk) begin
    if (reset) retire_count <= '0;
    else if (retire_now) retire_count <= retire_count + 32'd1;
  end
`endif

endmodule
